frame_presence_monitor: RTL and testbench
=========================================

# frame_presence_monitor

Multi-channel, per-frame presence detector for the VGA game pipeline. It watches N object draw-request lines and flags a channel as absent once that channel has drawn nothing for MISS_FRAMES consecutive complete frames. Game-state logic uses it to detect win and loss conditions, such as all aliens destroyed or the player sprite gone. It sits beside the object mux and is clocked by the pixel clock, with startOfFrame as its frame boundary.

## Interface
- NUM_CH, 4: number of monitored channels, 1..16.
- MISS_FRAMES, 1: consecutive empty complete frames needed before a channel is declared absent, 1..255.
- clk  in  1  pixel clock.
- resetN  in  1  reset resetN, asynchronous, active-low; clock clk.
- startOfFrame  in  1  one-cycle pulse marking a frame boundary.
- drawReq  in  NUM_CH  per-channel draw request, level or pulse.
- chMask  in  NUM_CH  1 = channel monitored; 0 = channel ignored.
- rearm  in  1  synchronous one-cycle clear of all state back to DISARMED.
- armed  out  1  high once the first frame boundary has been seen.
- absent  out  NUM_CH  per-channel absent flag, registered.
- absentPulse  out  NUM_CH  one-cycle pulse when the matching absent bit rises.
- allAbsent  out  1  every masked-in channel is absent, and at least one channel is masked in.

## Operation
- Top-level state machine (FSM):
  - States: DISARMED, ARMED. Reset and rearm both go to DISARMED.
  - DISARMED → ARMED on startOfFrame. The partial frame before the first boundary is never evaluated.
- Per-channel state:
  - seen flag.
  - Miss counter, CNT_W = $clog2(MISS_FRAMES+1) bits wide, saturating at MISS_FRAMES.
  - absent bit.
- seen update:
  - seen is set on any cycle where drawReq[i] is high.
  - At startOfFrame, seen is reloaded with drawReq[i], not cleared to 0. A request coincident with the boundary counts toward the new frame.
- Evaluation happens at startOfFrame while ARMED, per channel:
  - If seen: counter ← 0.
  - Else: counter ← min(counter+1, MISS_FRAMES).
  - When the counter becomes equal to MISS_FRAMES: absent[i] ← 1, and absentPulse[i] is high for that one cycle.
- Once saturated, further empty frames cause no new pulse.
- Masked channels (chMask[i]=0):
  - Counter, seen and absent are held at 0, and no pulse is produced.
  - Unmasking a channel starts it fresh; its first evaluation is at the next boundary.
- allAbsent = (&(absent | ~chMask)) && (|chMask), registered alongside absent.
- Simultaneous events:
  - rearm with startOfFrame: rearm wins. The FSM stays DISARMED and the next boundary arms it.
  - rearm with drawReq: cleared.
- Reset values: armed=0, absent=0, absentPulse=0, allAbsent=0, all counters and seen flags 0.

## Timing
- Inputs are sampled at posedge clk.
- absent, absentPulse and allAbsent change on the edge that samples startOfFrame. They are visible in the cycle after the startOfFrame pulse cycle, giving 1-cycle latency.
- armed rises on that same edge.
- The earliest possible absent assertion, with MISS_FRAMES=1 and no draws, is one cycle after the second startOfFrame following reset.
- Asserting resetN mid-frame clears everything immediately and asynchronously. Deassertion is assumed synchronised upstream.
- absentPulse is never high for more than one consecutive cycle.

## Configuration
- FRAME_PRESENCE_LIVE_EN.
- Defined (live mode):
  - At an ARMED boundary where seen[i]=1, absent[i] ← 0 and the counter ← 0.
  - A channel that reappears is no longer absent; allAbsent follows.
- Undefined (sticky mode, default):
  - absent bits hold until rearm or reset.
  - seen only resets the counter of channels not yet absent.

## Structure
- Shared package frame_presence_pkg:
  - fpm_state_t enum {DISARMED, ARMED}.
  - localparam MAX_CH = 16 and MAX_MISS = 255.
  - Function cnt_w(miss) returning $clog2(miss+1).
- Sub-module presence_channel: one instance per channel via generate. It holds the seen flag, the counter, absent and pulse, and takes evaluate/clear/mask strobes from the top.
- The top level holds the FSM and the allAbsent reduction.

## Test plan
- Reset, NUM_CH=4, MISS_FRAMES=1, chMask=4'b1111, no draws: SOF#1 → armed=1 and absent=0; SOF#2 → absent=4'b1111, absentPulse=4'b1111 for 1 cycle, allAbsent=1.
- MISS_FRAMES=3, channel 0 draws one pixel in frame 2 of 5: absent[0] rises only after three subsequent empty frames, exactly one pulse. Channels 1–3 assert after the 3rd empty frame.
- drawReq[1] high only in the cycle coinciding with startOfFrame: channel 1 is counted as present for the new frame; its counter is 0 at the next boundary.
- chMask=4'b0011, channels 0–1 empty, channels 2–3 empty: allAbsent=1 while absent[3:2]=0. With chMask=0: allAbsent stays 0.
- rearm coincident with startOfFrame after absent=4'b1111: all outputs 0, armed=0; the next SOF re-arms and evaluation restarts.
- Live vs sticky: absent[2]=1, then channel 2 draws in a frame. With FRAME_PRESENCE_LIVE_EN: absent[2]=0 after the next SOF. Without it: absent[2] stays 1.

Source files
------------

// File: rtl/frame_presence_pkg.sv
// Shared types and helpers for the frame presence monitor.
// Optional build macro: FRAME_PRESENCE_LIVE_EN (live re-presence mode).
package frame_presence_pkg;

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } fpm_state_t;

    localparam int MAX_CH   = 16;
    localparam int MAX_MISS = 255;

    function automatic int cnt_w(input int miss);
        return $clog2(miss + 1);
    endfunction

endpackage

// File: rtl/frame_presence_monitor_channel.sv
// Per-channel presence tracker: seen flag, saturating miss counter, absent bit.
// Optional build macro: FRAME_PRESENCE_LIVE_EN (absent clears on reappearance).
import frame_presence_pkg::*;

module presence_channel #(
    parameter int MISS_FRAMES = 1,
    parameter int CNT_W       = cnt_w(MISS_FRAMES)
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_draw,
    input  logic i_sof,
    input  logic i_eval,
    input  logic i_clear,
    input  logic i_mask,
    output logic o_absent,
    output logic o_absent_nxt,
    output logic o_pulse
);

    localparam logic [CNT_W-1:0] MISS_C = CNT_W'(MISS_FRAMES);

    logic             r_seen;
    logic [CNT_W-1:0] r_cnt;
    logic             r_absent;
    logic             r_pulse;

    logic             w_seen_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_sat;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_abs_nxt;
    logic             w_pulse_nxt;
    logic             w_reset_cnt;

    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
    assign w_cnt_sat = (w_cnt_inc >= {1'b0, MISS_C}) ? MISS_C
                                                     : w_cnt_inc[CNT_W-1:0];

`ifdef FRAME_PRESENCE_LIVE_EN
    assign w_reset_cnt = r_seen;
`else
    // Once absent, a late draw no longer rewinds the counter.
    assign w_reset_cnt = r_seen && !r_absent;
`endif

    always_comb begin
        w_seen_nxt  = i_sof ? i_draw : (r_seen | i_draw);
        w_cnt_nxt   = r_cnt;
        w_abs_nxt   = r_absent;
        w_pulse_nxt = 1'b0;
        if (i_clear || !i_mask) begin
            w_seen_nxt = 1'b0;
            w_cnt_nxt  = '0;
            w_abs_nxt  = 1'b0;
        end else if (i_eval) begin
            if (w_reset_cnt) begin
                w_cnt_nxt = '0;
`ifdef FRAME_PRESENCE_LIVE_EN
                w_abs_nxt = 1'b0;
`endif
            end else if (!r_seen) begin
                w_cnt_nxt = w_cnt_sat;
                if (w_cnt_sat == MISS_C && r_cnt != MISS_C) begin
                    w_abs_nxt   = 1'b1;
                    w_pulse_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_seen   <= 1'b0;
            r_cnt    <= '0;
            r_absent <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_seen   <= w_seen_nxt;
            r_cnt    <= w_cnt_nxt;
            r_absent <= w_abs_nxt;
            r_pulse  <= w_pulse_nxt;
        end
    end

    assign o_absent     = r_absent;
    assign o_absent_nxt = w_abs_nxt;
    assign o_pulse      = r_pulse;

endmodule

// File: rtl/frame_presence_monitor.sv
// Multi-channel per-frame presence monitor: arming FSM plus allAbsent reduction.
// Optional build macro: FRAME_PRESENCE_LIVE_EN (live re-presence mode).
import frame_presence_pkg::*;

module frame_presence_monitor #(
    parameter int NUM_CH      = 4,
    parameter int MISS_FRAMES = 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic [NUM_CH-1:0] drawReq,
    input  logic [NUM_CH-1:0] chMask,
    input  logic              rearm,
    output logic              armed,
    output logic [NUM_CH-1:0] absent,
    output logic [NUM_CH-1:0] absentPulse,
    output logic              allAbsent
);

    fpm_state_t r_state;
    fpm_state_t w_state_nxt;
    logic       w_eval;
    logic       r_all_absent;

    logic [NUM_CH-1:0] w_abs_nxt;
    logic              w_all_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        unique case (r_state)
            DISARMED: begin
                if (!rearm && startOfFrame) w_state_nxt = ARMED;
            end
            ARMED: begin
                if (rearm) w_state_nxt = DISARMED;
                else       w_eval      = startOfFrame;
            end
            default: w_state_nxt = DISARMED;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= DISARMED;
        else         r_state <= w_state_nxt;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        presence_channel #(
            .MISS_FRAMES (MISS_FRAMES)
        ) u_ch (
            .clk          (clk),
            .resetN       (resetN),
            .i_draw       (drawReq[g]),
            .i_sof        (startOfFrame),
            .i_eval       (w_eval),
            .i_clear      (rearm),
            .i_mask       (chMask[g]),
            .o_absent     (absent[g]),
            .o_absent_nxt (w_abs_nxt[g]),
            .o_pulse      (absentPulse[g])
        );
    end

    // Reduced from next-state bits so it moves on the same edge as absent.
    assign w_all_nxt = (&(w_abs_nxt | ~chMask)) && (|chMask);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_all_absent <= 1'b0;
        else         r_all_absent <= w_all_nxt;
    end

    assign armed     = (r_state == ARMED);
    assign allAbsent = r_all_absent;

endmodule

// File: tb/tb_frame_presence_monitor.sv
// Directed bench: MISS_FRAMES=1 and MISS_FRAMES=3 instances share stimulus.
module tb_frame_presence_monitor;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic [3:0] drawReq = 4'b0;
    logic [3:0] chMask = 4'b1111;
    logic       rearm = 1'b0;

    logic       armed1, all1, armed3, all3;
    logic [3:0] abs1, pls1, abs3, pls3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_presence_monitor #(.NUM_CH(4), .MISS_FRAMES(1)) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .drawReq(drawReq), .chMask(chMask), .rearm(rearm),
        .armed(armed1), .absent(abs1), .absentPulse(pls1),
        .allAbsent(all1)
    );

    frame_presence_monitor #(.NUM_CH(4), .MISS_FRAMES(3)) dut3 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .drawReq(drawReq), .chMask(chMask), .rearm(rearm),
        .armed(armed3), .absent(abs3), .absentPulse(pls3),
        .allAbsent(all3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof(input logic [3:0] d);
        drawReq = d;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        drawReq = 4'b0;
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({armed1, abs1, pls1, all1} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_m1 got %b exp 0", {armed1, abs1, pls1, all1});
        end
        n_cmp++;
        if ({armed3, abs3, pls3, all3} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_m3 got %b exp 0", {armed3, abs3, pls3, all3});
        end
        @(posedge clk);
        #1 resetN = 1'b1;
        tick();
    endtask

    task automatic test_first_absent();
        chMask = 4'b1111;
        sof(4'b0);
        n_cmp++;
        if (armed1 !== 1'b1 || abs1 !== 4'b0) begin
            n_bad++;
            $display("FAIL arm_sof1 armed %b abs %b exp 1 0000", armed1, abs1);
        end
        frame(5);
        sof(4'b0);
        n_cmp++;
        if (abs1 !== 4'b1111 || pls1 !== 4'b1111 || all1 !== 1'b1) begin
            n_bad++;
            $display("FAIL sof2_abs abs %b pls %b all %b exp 1111 1111 1",
                     abs1, pls1, all1);
        end
        n_cmp++;
        if (abs3 !== 4'b0 || pls3 !== 4'b0) begin
            n_bad++;
            $display("FAIL sof2_m3 abs %b pls %b exp 0000 0000", abs3, pls3);
        end
        tick();
        n_cmp++;
        if (pls1 !== 4'b0 || abs1 !== 4'b1111) begin
            n_bad++;
            $display("FAIL pulse_1cyc pls %b abs %b exp 0000 1111", pls1, abs1);
        end
    endtask

    task automatic test_rearm_sof();
        frame(3);
        rearm = 1'b1;
        sof(4'b0);
        rearm = 1'b0;
        n_cmp++;
        if ({armed1, abs1, pls1, all1} !== 10'b0) begin
            n_bad++;
            $display("FAIL rearm_sof got %b exp 0", {armed1, abs1, pls1, all1});
        end
        frame(3);
        sof(4'b0);
        n_cmp++;
        if (armed1 !== 1'b1 || abs1 !== 4'b0) begin
            n_bad++;
            $display("FAIL rearm_rearm armed %b abs %b exp 1 0000", armed1, abs1);
        end
        frame(3);
        sof(4'b0);
        n_cmp++;
        if (abs1 !== 4'b1111 || pls1 !== 4'b1111) begin
            n_bad++;
            $display("FAIL rearm_eval abs %b pls %b exp 1111 1111", abs1, pls1);
        end
    endtask

    task automatic test_miss3();
        logic [3:0] exp_abs [5];
        logic [3:0] exp_pls [5];
        exp_abs = '{4'b0000, 4'b0000, 4'b1110, 4'b1110, 4'b1111};
        exp_pls = '{4'b0000, 4'b0000, 4'b1110, 4'b0000, 4'b0001};
        do_rearm();
        sof(4'b0);
        for (int f = 0; f < 5; f++) begin
            frame(2);
            if (f == 1) begin
                drawReq = 4'b0001;
                tick();
                drawReq = 4'b0;
            end
            frame(2);
            sof(4'b0);
            n_cmp++;
            if (abs3 !== exp_abs[f] || pls3 !== exp_pls[f]) begin
                n_bad++;
                $display("FAIL miss3_f%0d abs %b pls %b exp %b %b",
                         f, abs3, pls3, exp_abs[f], exp_pls[f]);
            end
        end
        tick();
        n_cmp++;
        if (pls3 !== 4'b0) begin
            n_bad++;
            $display("FAIL miss3_pw pls %b exp 0000", pls3);
        end
        frame(3);
        sof(4'b0);
        n_cmp++;
        if (pls3 !== 4'b0 || abs3 !== 4'b1111 || all3 !== 1'b1) begin
            n_bad++;
            $display("FAIL miss3_sat pls %b abs %b all %b exp 0000 1111 1",
                     pls3, abs3, all3);
        end
    endtask

    task automatic test_sof_coincident();
        do_rearm();
        sof(4'b0);
        frame(3);
        sof(4'b0010);
        frame(3);
        sof(4'b0);
        n_cmp++;
        if (abs3 !== 4'b0) begin
            n_bad++;
            $display("FAIL coinc_e2 abs %b exp 0000", abs3);
        end
        frame(3);
        sof(4'b0);
        n_cmp++;
        if (abs3 !== 4'b1101 || pls3 !== 4'b1101) begin
            n_bad++;
            $display("FAIL coinc_e3 abs %b pls %b exp 1101 1101", abs3, pls3);
        end
    endtask

    task automatic test_mask();
        do_rearm();
        chMask = 4'b0011;
        sof(4'b0);
        frame(3);
        sof(4'b0);
        n_cmp++;
        if (abs1 !== 4'b0011 || all1 !== 1'b1 || pls1 !== 4'b0011) begin
            n_bad++;
            $display("FAIL mask_0011 abs %b all %b pls %b exp 0011 1 0011",
                     abs1, all1, pls1);
        end
        chMask = 4'b0000;
        tick();
        n_cmp++;
        if (abs1 !== 4'b0 || all1 !== 1'b0) begin
            n_bad++;
            $display("FAIL mask_0000 abs %b all %b exp 0000 0", abs1, all1);
        end
        frame(2);
        sof(4'b0);
        n_cmp++;
        if (abs1 !== 4'b0 || all1 !== 1'b0 || pls1 !== 4'b0) begin
            n_bad++;
            $display("FAIL mask_none abs %b all %b pls %b exp 0000 0 0000",
                     abs1, all1, pls1);
        end
        chMask = 4'b1111;
    endtask

    task automatic test_live_sticky();
        logic [3:0] e_abs;
        logic [3:0] e_pls;
        logic       e_all;
        do_rearm();
        sof(4'b0);
        frame(3);
        sof(4'b0);
        n_cmp++;
        if (abs1 !== 4'b1111) begin
            n_bad++;
            $display("FAIL live_pre abs %b exp 1111", abs1);
        end
        frame(2);
        drawReq = 4'b0100;
        tick();
        drawReq = 4'b0;
        frame(2);
        sof(4'b0);
`ifdef FRAME_PRESENCE_LIVE_EN
        e_abs = 4'b1011;
        e_all = 1'b0;
`else
        e_abs = 4'b1111;
        e_all = 1'b1;
`endif
        n_cmp++;
        if (abs1 !== e_abs || all1 !== e_all || pls1 !== 4'b0) begin
            n_bad++;
            $display("FAIL live_seen abs %b all %b pls %b exp %b %b 0000",
                     abs1, all1, pls1, e_abs, e_all);
        end
        frame(3);
        sof(4'b0);
`ifdef FRAME_PRESENCE_LIVE_EN
        e_pls = 4'b0100;
`else
        e_pls = 4'b0000;
`endif
        n_cmp++;
        if (abs1 !== 4'b1111 || pls1 !== e_pls || all1 !== 1'b1) begin
            n_bad++;
            $display("FAIL live_again abs %b pls %b all %b exp 1111 %b 1",
                     abs1, pls1, all1, e_pls);
        end
    endtask

    task automatic test_async_reset();
        frame(2);
        #2 resetN = 1'b0;
        #1;
        n_cmp++;
        if ({armed1, abs1, all1, armed3, abs3, all3} !== 12'b0) begin
            n_bad++;
            $display("FAIL async_rst got %b exp 0",
                     {armed1, abs1, all1, armed3, abs3, all3});
        end
        @(posedge clk);
        #1 resetN = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_absent();
        test_rearm_sof();
        test_miss3();
        test_sof_coincident();
        test_mask();
        test_live_sticky();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
